// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - two-to-one no-ID read-only AXI arbiter, one burst outstanding
// AXI_RD_ARB_RR_EN selects round-robin tie breaking; fixed priority (port 0) otherwise.
module axi_rd_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] s0_araddr_i,
    input  logic [7:0]  s0_arlen_i,
    input  logic [2:0]  s0_arsize_i,
    input  logic [1:0]  s0_arburst_i,
    input  logic        s0_arvalid_i,
    output logic        s0_arready_o,
    output logic [63:0] s0_rdata_o,
    output logic [1:0]  s0_rresp_o,
    output logic        s0_rlast_o,
    output logic        s0_rvalid_o,
    input  logic        s0_rready_i,
    input  logic [31:0] s1_araddr_i,
    input  logic [7:0]  s1_arlen_i,
    input  logic [2:0]  s1_arsize_i,
    input  logic [1:0]  s1_arburst_i,
    input  logic        s1_arvalid_i,
    output logic        s1_arready_o,
    output logic [63:0] s1_rdata_o,
    output logic [1:0]  s1_rresp_o,
    output logic        s1_rlast_o,
    output logic        s1_rvalid_o,
    input  logic        s1_rready_i,
    output logic [31:0] m_araddr_o,
    output logic [7:0]  m_arlen_o,
    output logic [2:0]  m_arsize_o,
    output logic [1:0]  m_arburst_o,
    output logic        m_arvalid_o,
    input  logic        m_arready_i,
    input  logic [63:0] m_rdata_i,
    input  logic [1:0]  m_rresp_i,
    input  logic        m_rlast_i,
    input  logic        m_rvalid_i,
    output logic        m_rready_o,
    output logic        grant_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q, last_d;
    logic   winner;

`ifdef AXI_RD_ARB_RR_EN
    // On a tie the port that did not win last time takes the bus.
    assign winner = (s0_arvalid_i && s1_arvalid_i) ? ~last_q : ~s0_arvalid_i;
`else
    assign winner = ~s0_arvalid_i;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        m_araddr_o   = '0;
        m_arlen_o    = '0;
        m_arsize_o   = '0;
        m_arburst_o  = '0;
        m_arvalid_o  = 1'b0;
        m_rready_o   = 1'b0;
        s0_arready_o = 1'b0;
        s1_arready_o = 1'b0;
        s0_rvalid_o  = 1'b0;
        s1_rvalid_o  = 1'b0;
        s0_rdata_o   = '0;
        s1_rdata_o   = '0;
        s0_rresp_o   = '0;
        s1_rresp_o   = '0;
        s0_rlast_o   = 1'b0;
        s1_rlast_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (s0_arvalid_i || s1_arvalid_i) begin
                    grant_d = winner;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                m_araddr_o   = grant_q ? s1_araddr_i  : s0_araddr_i;
                m_arlen_o    = grant_q ? s1_arlen_i   : s0_arlen_i;
                m_arsize_o   = grant_q ? s1_arsize_i  : s0_arsize_i;
                m_arburst_o  = grant_q ? s1_arburst_i : s0_arburst_i;
                m_arvalid_o  = grant_q ? s1_arvalid_i : s0_arvalid_i;
                s0_arready_o = ~grant_q & m_arready_i;
                s1_arready_o = grant_q & m_arready_i;
                if (m_arvalid_o && m_arready_i) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                // R payload is broadcast; only the valid/ready pair is steered.
                s0_rdata_o  = m_rdata_i;
                s1_rdata_o  = m_rdata_i;
                s0_rresp_o  = m_rresp_i;
                s1_rresp_o  = m_rresp_i;
                s0_rlast_o  = m_rlast_i;
                s1_rlast_o  = m_rlast_i;
                s0_rvalid_o = ~grant_q & m_rvalid_i;
                s1_rvalid_o = grant_q & m_rvalid_i;
                m_rready_o  = grant_q ? s1_rready_i : s0_rready_i;
                if (m_rvalid_i && m_rready_o && m_rlast_i) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb/tb_axi_rd_arbiter.sv - directed and randomized checks of axi_rd_arbiter
module tb_axi_rd_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] s0_araddr_i, s1_araddr_i, m_araddr_o;
    logic [7:0]  s0_arlen_i, s1_arlen_i, m_arlen_o;
    logic [2:0]  s0_arsize_i, s1_arsize_i, m_arsize_o;
    logic [1:0]  s0_arburst_i, s1_arburst_i, m_arburst_o;
    logic        s0_arvalid_i, s1_arvalid_i, m_arvalid_o;
    logic        s0_arready_o, s1_arready_o, m_arready_i;
    logic [63:0] s0_rdata_o, s1_rdata_o, m_rdata_i;
    logic [1:0]  s0_rresp_o, s1_rresp_o, m_rresp_i;
    logic        s0_rlast_o, s1_rlast_o, m_rlast_i;
    logic        s0_rvalid_o, s1_rvalid_o, m_rvalid_i;
    logic        s0_rready_i, s1_rready_i, m_rready_o;
    logic        grant_o, busy_o;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    axi_rd_arbiter dut (
        .clock(clock), .reset(reset),
        .s0_araddr_i(s0_araddr_i), .s0_arlen_i(s0_arlen_i), .s0_arsize_i(s0_arsize_i),
        .s0_arburst_i(s0_arburst_i), .s0_arvalid_i(s0_arvalid_i), .s0_arready_o(s0_arready_o),
        .s0_rdata_o(s0_rdata_o), .s0_rresp_o(s0_rresp_o), .s0_rlast_o(s0_rlast_o),
        .s0_rvalid_o(s0_rvalid_o), .s0_rready_i(s0_rready_i),
        .s1_araddr_i(s1_araddr_i), .s1_arlen_i(s1_arlen_i), .s1_arsize_i(s1_arsize_i),
        .s1_arburst_i(s1_arburst_i), .s1_arvalid_i(s1_arvalid_i), .s1_arready_o(s1_arready_o),
        .s1_rdata_o(s1_rdata_o), .s1_rresp_o(s1_rresp_o), .s1_rlast_o(s1_rlast_o),
        .s1_rvalid_o(s1_rvalid_o), .s1_rready_i(s1_rready_i),
        .m_araddr_o(m_araddr_o), .m_arlen_o(m_arlen_o), .m_arsize_o(m_arsize_o),
        .m_arburst_o(m_arburst_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rlast_i(m_rlast_i),
        .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        s0_araddr_i = '0; s0_arlen_i = '0; s0_arsize_i = 3'd3; s0_arburst_i = 2'd1;
        s1_araddr_i = '0; s1_arlen_i = '0; s1_arsize_i = 3'd3; s1_arburst_i = 2'd1;
        s0_arvalid_i = 1'b0; s1_arvalid_i = 1'b0;
        s0_rready_i = 1'b0;  s1_rready_i = 1'b0;
        m_arready_i = 1'b0;  m_rvalid_i = 1'b0;
        m_rdata_i = '0; m_rresp_i = '0; m_rlast_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic logic [63:0] beat_data(input logic [31:0] a, input int b);
        logic [7:0] lo;
        lo = b[7:0];
        return {a, 24'h5a5a5a, lo};
    endfunction

    // Transaction-level reference: each requester keeps arvalid up while it has
    // work, so every arbitration point is a tie until one side runs dry.
    task automatic run_traffic(input int n0, input int n1, input int maxlen, input bit rnd);
        logic [31:0] ra [2][16];
        logic [7:0]  rl [2][16];
        int n [2];
        int sent [2];
        int done [2];
        int rbeat [2];
        int ord [32];
        int ord_n, ord_i, lastp, cyc, i0, i1, w, hs_port;
        bit got [2];
        bit beat [2];
        bit ar_hs, r_hs, r_last;
        logic sl_busy;
        logic [31:0] sl_addr, cap_addr;
        logic [7:0] sl_len, sl_beat, cap_len;

        n[0] = n0; n[1] = n1;
        for (int p = 0; p < 2; p++) begin
            sent[p] = 0; done[p] = 0; rbeat[p] = 0;
            for (int i = 0; i < 16; i++) begin
                ra[p][i] = (p == 0 ? 32'h8000_0000 : 32'h4000_0000) + 32'(i * 256)
                         + 32'($urandom_range(0, 15) * 8);
                rl[p][i] = rnd ? 8'($urandom_range(0, maxlen)) : 8'(maxlen);
            end
        end

        ord_n = 0; ord_i = 0; lastp = 1; i0 = 0; i1 = 0;
        while (i0 < n0 || i1 < n1) begin
`ifdef AXI_RD_ARB_RR_EN
            if (i0 < n0 && i1 < n1) w = 1 - lastp;
`else
            if (i0 < n0 && i1 < n1) w = 0;
`endif
            else w = (i0 < n0) ? 0 : 1;
            ord[ord_n] = w;
            ord_n++;
            lastp = w;
            if (w == 0) i0++; else i1++;
        end

        sl_busy = 1'b0; sl_addr = '0; sl_len = '0; sl_beat = '0;
        cap_addr = '0; cap_len = '0;
        for (cyc = 0; cyc < 3000; cyc++) begin
            if (done[0] == n0 && done[1] == n1 && !busy_o) break;

            s0_arvalid_i = (sent[0] < n0);
            s1_arvalid_i = (sent[1] < n1);
            s0_araddr_i = '0; s0_arlen_i = '0; s1_araddr_i = '0; s1_arlen_i = '0;
            if (sent[0] < n0) begin s0_araddr_i = ra[0][sent[0]]; s0_arlen_i = rl[0][sent[0]]; end
            if (sent[1] < n1) begin s1_araddr_i = ra[1][sent[1]]; s1_arlen_i = rl[1][sent[1]]; end
            s0_rready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            s1_rready_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            m_arready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_rvalid_i  = sl_busy && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            m_rdata_i   = beat_data(sl_addr, int'(sl_beat));
            m_rlast_i   = sl_busy && (sl_beat == sl_len);
            #1;

            ar_hs = m_arvalid_o && m_arready_i;
            got[0] = s0_arvalid_i && s0_arready_o;
            got[1] = s1_arvalid_i && s1_arready_o;
            if (ar_hs) begin
                hs_port = got[1] ? 1 : 0;
                cap_addr = m_araddr_o;
                cap_len = m_arlen_o;
                chk("ar_one_port", 64'(int'(got[0]) + int'(got[1])), 64'd1);
                if (ord_i < ord_n) begin
                    chk("grant_order", 64'(hs_port), 64'(ord[ord_i]));
                    chk("grant_o", 64'(grant_o), 64'(ord[ord_i]));
                    chk("ar_addr", 64'(m_araddr_o), 64'(ra[ord[ord_i]][sent[ord[ord_i]]]));
                    chk("ar_len", 64'(m_arlen_o), 64'(rl[ord[ord_i]][sent[ord[ord_i]]]));
                end else begin
                    chk("extra_ar", 64'd1, 64'd0);
                end
                ord_i++;
            end

            r_hs = m_rvalid_i && m_rready_o;
            r_last = m_rlast_i;
            beat[0] = s0_rvalid_o && s0_rready_i;
            beat[1] = s1_rvalid_o && s1_rready_i;
            if (r_hs) chk("r_route", 64'(int'(beat[0]) + int'(beat[1])), 64'd1);
            for (int p = 0; p < 2; p++) begin
                if (beat[p]) begin
                    if (done[p] < sent[p]) begin
                        chk("r_data", p == 0 ? s0_rdata_o : s1_rdata_o,
                            beat_data(ra[p][done[p]], rbeat[p]));
                        chk("r_last", 64'(p == 0 ? s0_rlast_o : s1_rlast_o),
                            64'(rbeat[p] == int'(rl[p][done[p]])));
                        if (rbeat[p] == int'(rl[p][done[p]])) begin
                            done[p]++;
                            rbeat[p] = 0;
                        end else begin
                            rbeat[p]++;
                        end
                    end else begin
                        chk("spurious_r", 64'd1, 64'd0);
                    end
                end
            end

            step();
            for (int p = 0; p < 2; p++) if (got[p]) sent[p]++;
            if (ar_hs) begin
                sl_busy = 1'b1; sl_addr = cap_addr; sl_len = cap_len; sl_beat = '0;
            end
            if (r_hs) begin
                if (r_last) sl_busy = 1'b0;
                else sl_beat = sl_beat + 8'd1;
            end
        end
        chk("traffic_timeout", 64'(cyc < 3000), 64'd1);
        chk("traffic_done0", 64'(done[0]), 64'(n0));
        chk("traffic_done1", 64'(done[1]), 64'(n1));
        chk("traffic_order_len", 64'(ord_i), 64'(ord_n));
        idle_in();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state with live-looking downstream inputs.
        reset = 1'b1;
        idle_in();
        m_arready_i = 1'b1; m_rvalid_i = 1'b1; s0_rready_i = 1'b1; s1_rready_i = 1'b1;
        step();
        step();
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_m_arvalid", 64'(m_arvalid_o), 64'd0);
        chk("rst_m_rready", 64'(m_rready_o), 64'd0);
        chk("rst_arready", 64'({s0_arready_o, s1_arready_o}), 64'd0);
        chk("rst_rvalid", 64'({s0_rvalid_o, s1_rvalid_o}), 64'd0);
        reset = 1'b0;
        idle_in();
        step();

        // Single-beat read from s0.
        s0_arvalid_i = 1'b1; s0_araddr_i = 32'h8000_0000; s0_arlen_i = 8'd0;
        m_arready_i = 1'b1; s0_rready_i = 1'b1; s1_rready_i = 1'b1;
        #1;
        chk("single_c0_arvalid", 64'(m_arvalid_o), 64'd0);
        step();
        chk("single_c1_arvalid", 64'(m_arvalid_o), 64'd1);
        chk("single_c1_araddr", 64'(m_araddr_o), 64'h8000_0000);
        chk("single_c1_arsize", 64'(m_arsize_o), 64'd3);
        chk("single_c1_arready", 64'({s0_arready_o, s1_arready_o}), 64'b10);
        step();
        s0_arvalid_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 64'h1122_3344_5566_7788; m_rlast_i = 1'b1;
        #1;
        chk("single_c2_arvalid", 64'(m_arvalid_o), 64'd0);
        chk("single_c2_s0_rvalid", 64'(s0_rvalid_o), 64'd1);
        chk("single_c2_rdata", s0_rdata_o, 64'h1122_3344_5566_7788);
        chk("single_c2_s1_rvalid", 64'(s1_rvalid_o), 64'd0);
        chk("single_c2_m_rready", 64'(m_rready_o), 64'd1);
        step();
        m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
        #1;
        chk("single_c3_busy", 64'(busy_o), 64'd0);
        chk("single_c3_s1_rvalid", 64'(s1_rvalid_o), 64'd0);

        // Tie: four single-beat reads from each side, always ready.
        do_reset();
        run_traffic(4, 4, 0, 1'b0);

        // Burst on s1 with an rvalid gap; s0 arrives mid-burst.
        do_reset();
        s1_arvalid_i = 1'b1; s1_araddr_i = 32'h4000_1000; s1_arlen_i = 8'd3;
        m_arready_i = 1'b1; s0_rready_i = 1'b1; s1_rready_i = 1'b1;
        step();
        #1;
        chk("burst_s1_arready", 64'(s1_arready_o), 64'd1);
        step();
        s1_arvalid_i = 1'b0;
        s0_arvalid_i = 1'b1; s0_araddr_i = 32'h8000_2000; s0_arlen_i = 8'd0;
        begin
            logic [4:0] gap_pat;
            int bn;
            gap_pat = 5'b11011;
            bn = 0;
            for (int c = 0; c < 5; c++) begin
                m_rvalid_i = gap_pat[c];
                m_rdata_i = 64'hB0 + 64'(bn);
                m_rlast_i = (bn == 3);
                #1;
                chk("burst_s0_arready_held", 64'(s0_arready_o), 64'd0);
                chk("burst_s0_rvalid", 64'(s0_rvalid_o), 64'd0);
                if (gap_pat[c]) begin
                    chk("burst_s1_rvalid", 64'(s1_rvalid_o), 64'd1);
                    chk("burst_s1_rdata", s1_rdata_o, 64'hB0 + 64'(bn));
                    bn++;
                end else begin
                    chk("burst_gap_rvalid", 64'(s1_rvalid_o), 64'd0);
                end
                step();
            end
        end
        m_rvalid_i = 1'b0; m_rlast_i = 1'b0;
        #1;
        chk("burst_bubble_busy", 64'(busy_o), 64'd0);
        chk("burst_bubble_arvalid", 64'(m_arvalid_o), 64'd0);
        step();
        chk("burst_s0_granted", 64'({m_arvalid_o, grant_o, s0_arready_o}), 64'b101);
        chk("burst_s0_araddr", 64'(m_araddr_o), 64'h8000_2000);
        step();
        s0_arvalid_i = 1'b0;
        m_rvalid_i = 1'b1; m_rlast_i = 1'b1;
        step();
        idle_in();

        // Address backpressure with a stray rvalid, then R backpressure.
        do_reset();
        s0_arvalid_i = 1'b1; s0_araddr_i = 32'h8000_3000; s0_arlen_i = 8'd1;
        step();
        m_rvalid_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_araddr_stable", 64'({m_arvalid_o, m_araddr_o}), {31'd0, 1'b1, 32'h8000_3000});
            chk("bp_arready_low", 64'(s0_arready_o), 64'd0);
            chk("bp_addr_rvalid_ignored", 64'({s0_rvalid_o, m_rready_o}), 64'd0);
            step();
        end
        m_arready_i = 1'b1; m_rvalid_i = 1'b0;
        #1;
        chk("bp_arready_pass", 64'(s0_arready_o), 64'd1);
        step();
        s0_arvalid_i = 1'b0; m_arready_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 64'hC0; m_rlast_i = 1'b0; s0_rready_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_r_hold", 64'({s0_rvalid_o, m_rready_o}), 64'b10);
            step();
        end
        s0_rready_i = 1'b1;
        #1;
        chk("bp_r_beat0", s0_rdata_o, 64'hC0);
        chk("bp_r_ready", 64'(m_rready_o), 64'd1);
        step();
        m_rdata_i = 64'hC1; m_rlast_i = 1'b1;
        #1;
        chk("bp_r_beat1", 64'({s0_rvalid_o, s0_rlast_o}), 64'b11);
        chk("bp_r_beat1_data", s0_rdata_o, 64'hC1);
        step();
        idle_in();
        #1;
        chk("bp_done_busy", 64'(busy_o), 64'd0);

        // Reset in the middle of an s1 burst.
        do_reset();
        s1_arvalid_i = 1'b1; s1_araddr_i = 32'h4000_5000; s1_arlen_i = 8'd3;
        m_arready_i = 1'b1; s1_rready_i = 1'b1;
        step();
        step();
        s1_arvalid_i = 1'b0;
        m_rvalid_i = 1'b1; m_rdata_i = 64'hD0;
        #1;
        chk("mid_beat1", 64'({s1_rvalid_o, m_rready_o}), 64'b11);
        step();
        reset = 1'b1;
        m_rdata_i = 64'hD1;
        step();
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_grant", 64'(grant_o), 64'd0);
        chk("mid_rst_valids", 64'({s0_rvalid_o, s1_rvalid_o, m_rready_o, m_arvalid_o,
                                   s0_arready_o, s1_arready_o}), 64'd0);
        idle_in();
        s1_arvalid_i = 1'b1; s1_araddr_i = 32'h4000_6000; s1_arlen_i = 8'd0;
        m_arready_i = 1'b1; s1_rready_i = 1'b1;
        step();
        chk("post_rst_grant", 64'({m_arvalid_o, grant_o, s1_arready_o}), 64'b111);
        chk("post_rst_araddr", 64'(m_araddr_o), 64'h4000_6000);
        step();
        s1_arvalid_i = 1'b0;
        m_rvalid_i = 1'b1; m_rlast_i = 1'b1; m_rdata_i = 64'hE0;
        #1;
        chk("post_rst_rdata", 64'({s1_rvalid_o, s1_rdata_o[7:0]}), {55'd0, 1'b1, 8'hE0});
        step();
        idle_in();

        // Randomized bursts, random backpressure on both channels.
        do_reset();
        run_traffic(6, 6, 7, 1'b1);
        do_reset();
        run_traffic(5, 3, 15, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
# axi_rd_arbiter

Two-to-one arbiter that shares one no-ID, read-only AXI master port between the instruction-fetch read path (port 0) and the data read path (port 1). It sits between the fetch/load units and the memory-side AXI crossbar, granting one complete read burst at a time. It carries at most one outstanding transaction, so R beats need no ID routing.

## Interface
Parameters:
- none

Ports:
- clock  input  1  clock; all state updates on its rising edge
- reset  input  1  synchronous, active-high reset
- s0  modport axi.slave_no_id_read_only  —  requester 0 (instruction fetch)
- s1  modport axi.slave_no_id_read_only  —  requester 1 (data read)
- m  modport axi.master_no_id_read_only  —  shared downstream port
- grant  output  1  index of the currently or last granted requester
- busy  output  1  high when the state is not IDLE

## Operation
- Registered state: `state` ∈ {IDLE, ADDR, DATA}, `grant`, and `last` (the previous winner).
- IDLE:
  - All `m.ar*` outputs are driven as 0; `m.rready`=0; both `sN.arready`=0; both `sN.rvalid`=0.
  - If any `sN.arvalid`=1, pick a winner, load `grant`, and go to ADDR. Otherwise stay in IDLE.
- ADDR:
  - `m.araddr/arlen/arsize/arburst/arvalid` = `s[grant]` equivalents.
  - `s[grant].arready` = `m.arready`; the other port's `arready`=0.
  - On `m.arvalid & m.arready`, go to DATA.
- DATA:
  - `m.arvalid`=0.
  - `s[grant].rvalid` = `m.rvalid` and `m.rready` = `s[grant].rready`; the other port's `rvalid`=0.
  - `rdata`, `rresp` and `rlast` are broadcast to both ports.
  - On `m.rvalid & m.rready & m.rlast`, set `last` = `grant` and go to IDLE.
- Burst length is arbitrary (1–256 beats). The grant is held until the `rlast` handshake.
- Requesters must hold `arvalid` and the AR payload stable until `arready`. A losing requester simply waits.
- Ties (both `arvalid` in IDLE) are resolved per Configuration.

## Timing
- Reset values: state=IDLE, grant=0, last=1, busy=0. All outputs are 0, including both `sN.arready` and `sN.rvalid`, `m.arvalid` and `m.rready`.
- Arbitration costs 1 cycle:
  - `sN.arvalid` rising in cycle T (IDLE) gives `m.arvalid`=1 in cycle T+1.
  - If `m.arready`=1 in T+1, the state is DATA in T+2.
- The R path is combinational pass-through with 0 added latency.
- Minimum single-beat transaction with an always-ready slave takes 3 cycles: IDLE → ADDR → DATA → IDLE.
- After the final beat, the state is IDLE for 1 cycle before the next grant. This bubble is mandatory.
- `m.rvalid` arriving in ADDR (protocol violation) is ignored: `sN.rvalid`=0 and `m.rready`=0.
- A new `arvalid` from the granted port while in DATA is not accepted until the next IDLE.
- Reset mid-transaction returns all state to the reset values immediately. Downstream is required to be reset in the same cycle, and no beat is completed.
- `busy` = (state≠IDLE), combinational from the state register.

## Configuration
- Macro: `AXI_RD_ARB_RR_EN`.
- Defined: round-robin arbitration. On a tie, the port ≠ `last` wins. Because `last` resets to 1, the first tie after reset goes to port 0.
- Undefined: fixed priority, port 0 always wins a tie. The `last` register is still maintained but does not affect selection.

## Test plan
- Single request: s0 requests `araddr`=0x8000_0000, `arlen`=0; slave `arready`=1; `rdata`=0x1122_3344_5566_7788 with `rlast`=1.
  - `m.arvalid` high exactly in cycle 1.
  - s0 sees `rvalid` with that data in cycle 2.
  - s1 sees `rvalid`=0 throughout.
  - `busy` returns to 0 in cycle 3.
- Tie, round-robin build: s0 and s1 both assert `arvalid` continuously for 4 single-beat reads each.
  - Grant order is 0,1,0,1,0,1,0,1.
  - With the macro undefined, order is 0,0,0,0,1,1,1,1.
- Burst: s1 requests `arlen`=3; slave drives 4 beats with an `rvalid` gap after beat 2; s0 requests mid-burst.
  - s1 receives all 4 beats in order.
  - s0 `arready` stays 0 until after s1's `rlast`, then s0 is granted 1 cycle later.
- Backpressure: slave holds `arready`=0 for 5 cycles.
  - `m.araddr` stays stable and `s[grant].arready`=0 for those cycles.
  - `s0.rready`=0 for 3 cycles with `m.rvalid`=1 gives `m.rready`=0 and no beat lost.
- Reset mid-burst: reset asserted in DATA after beat 1 of 4.
  - Next cycle: state IDLE, `busy`=0, `grant`=0, and all valids/readies 0.
  - After reset, a new s1 request is granted normally.
